soin_bpredictor_update_queue: RTL and testbench

In-order queue of in-flight branch predictions, sitting between the fetch-side bimodal predictor and the execute stage. Fetch pushes each predicted branch (PC, predicted direction/target, 20-bit lookup meta); execute resolves branches in program order. For each resolution the block pops the head, computes the saturated 2-bit counter byte and byte-enable, and drives the predictor's `execute_bpredictor_*` update port (24-bit meta). On a misprediction it also drives the fetch redirect and the RAS recovery, then flushes all younger entries.

---
 rtl/soin_bpredictor_update_queue.sv | 163 ++++++++++++++++
 tb/tb_soin_bpredictor_update_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/soin_bpredictor_update_queue.sv
// In-order queue of predicted branches between the bimodal predictor and execute.
// Pops the head on each resolve and drives the predictor update, fetch redirect and RAS recovery.
module soin_bpredictor_update_queue #(
   parameter int unsigned DEPTH_L    = 3,
   parameter int unsigned META_IN_W  = 20,
   parameter int unsigned META_OUT_W = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fetch_bpq_valid,
   input  logic [31:0]           fetch_bpq_PC,
   input  logic                  fetch_bpq_p_dir,
   input  logic [31:0]           fetch_bpq_p_target,
   input  logic [META_IN_W-1:0]  fetch_bpq_meta,
   output logic                  bpq_fetch_full,
   input  logic                  execute_bpq_resolve,
   input  logic                  execute_bpq_is_cond,
   input  logic                  execute_bpq_dir,
   input  logic [31:0]           execute_bpq_target,
   output logic                  bpq_bpredictor_update,
   output logic [31:0]           bpq_bpredictor_PC,
   output logic [31:0]           bpq_bpredictor_target,
   output logic                  bpq_bpredictor_dir,
   output logic                  bpq_bpredictor_miss,
   output logic [META_OUT_W-1:0] bpq_bpredictor_meta,
   output logic                  bpq_bpredictor_recover_ras,
   output logic                  bpq_fetch_redirect,
   output logic [31:0]           bpq_fetch_redirect_PC,
   output logic [DEPTH_L:0]      bpq_count,
   output logic                  bpq_error
);

   localparam int unsigned Depth = 2 ** DEPTH_L;

   logic [31:0]          r_pc    [Depth];
   logic                 r_pdir  [Depth];
   logic [31:0]          r_ptgt  [Depth];
   logic [META_IN_W-1:0] r_meta  [Depth];

   logic [DEPTH_L:0] r_head, r_tail;
   logic [DEPTH_L:0] w_head_d, w_tail_d, w_head_inc, w_tail_inc;

   logic                  r_update, r_miss, r_redirect, r_recover, r_dir, r_error;
   logic [31:0]           r_out_pc, r_out_tgt, r_redirect_pc;
   logic [META_OUT_W-1:0] r_out_meta;

   logic w_empty, w_full, w_push, w_pop, w_miss, w_push_wr;
   logic [DEPTH_L-1:0]   w_hidx, w_tidx;
   logic [31:0]          w_h_pc, w_h_ptgt, w_redirect_pc;
   logic                 w_h_pdir;
   logic [META_IN_W-1:0] w_h_meta;
   logic [1:0]           w_k, w_c, w_c_new;
   logic [2:0]           w_cidx;
   logic [7:0]           w_byte_new;
   logic [3:0]           w_be;
   logic [META_OUT_W-1:0] w_out_meta;

   assign w_hidx  = r_head[DEPTH_L-1:0];
   assign w_tidx  = r_tail[DEPTH_L-1:0];
   assign w_empty = (r_head == r_tail);
   assign w_full  = (w_hidx == w_tidx) && (r_head[DEPTH_L] != r_tail[DEPTH_L]);
   assign w_push  = fetch_bpq_valid & ~w_full;
   assign w_pop   = execute_bpq_resolve & ~w_empty;

   assign w_h_pc   = r_pc[w_hidx];
   assign w_h_pdir = r_pdir[w_hidx];
   assign w_h_ptgt = r_ptgt[w_hidx];
   assign w_h_meta = r_meta[w_hidx];

   assign w_miss = (execute_bpq_dir != w_h_pdir) |
                   (execute_bpq_dir & (execute_bpq_target != w_h_ptgt));
   assign w_redirect_pc = execute_bpq_dir ? execute_bpq_target : (w_h_pc + 32'd4);

   // Saturating update of the 2-bit counter picked by PC[3:2] inside the meta counter byte.
   always_comb begin
      w_k        = w_h_pc[3:2];
      w_cidx     = {w_k, 1'b0};
      w_byte_new = w_h_meta[15:8];
      w_c        = w_byte_new[w_cidx +: 2];
      w_c_new    = w_c;
      if (execute_bpq_dir) begin
         if (w_c != 2'b11) w_c_new = w_c + 2'd1;
      end else begin
         if (w_c != 2'b00) w_c_new = w_c - 2'd1;
      end
      w_byte_new[w_cidx +: 2] = w_c_new;
   end

   assign w_be       = 4'b0001 << w_h_pc[5:4];
   assign w_out_meta = {w_h_meta[19:16], w_be, w_byte_new, w_h_meta[7:0]};

   assign w_head_inc = r_head + {{DEPTH_L{1'b0}}, 1'b1};
   assign w_tail_inc = r_tail + {{DEPTH_L{1'b0}}, 1'b1};

   // A miss drops every younger entry along with any push arriving the same cycle.
   always_comb begin
      w_head_d  = r_head;
      w_tail_d  = r_tail;
      w_push_wr = 1'b0;
      if (w_pop) w_head_d = w_head_inc;
      if (w_pop && w_miss) begin
         w_tail_d = w_head_inc;
      end else if (w_push) begin
         w_tail_d  = w_tail_inc;
         w_push_wr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_wr) begin
         r_pc[w_tidx]   <= fetch_bpq_PC;
         r_pdir[w_tidx] <= fetch_bpq_p_dir;
         r_ptgt[w_tidx] <= fetch_bpq_p_target;
         r_meta[w_tidx] <= fetch_bpq_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_update      <= 1'b0;
         r_miss        <= 1'b0;
         r_redirect    <= 1'b0;
         r_recover     <= 1'b0;
         r_error       <= 1'b0;
         r_dir         <= 1'b0;
         r_out_pc      <= '0;
         r_out_tgt     <= '0;
         r_redirect_pc <= '0;
         r_out_meta    <= '0;
      end else begin
         r_head     <= w_head_d;
         r_tail     <= w_tail_d;
         r_update   <= w_pop & execute_bpq_is_cond;
         r_miss     <= w_pop & w_miss;
         r_redirect <= w_pop & w_miss;
         r_recover  <= w_pop & w_miss;
         if (execute_bpq_resolve && w_empty) r_error <= 1'b1;
         if (w_pop) begin
            r_dir         <= execute_bpq_dir;
            r_out_pc      <= w_h_pc;
            r_out_tgt     <= execute_bpq_target;
            r_redirect_pc <= w_redirect_pc;
            r_out_meta    <= w_out_meta;
         end
      end
   end

   assign bpq_fetch_full             = w_full;
   assign bpq_count                  = r_tail - r_head;
   assign bpq_error                  = r_error;
   assign bpq_bpredictor_update      = r_update;
   assign bpq_bpredictor_PC          = r_out_pc;
   assign bpq_bpredictor_target      = r_out_tgt;
   assign bpq_bpredictor_dir         = r_dir;
   assign bpq_bpredictor_miss        = r_miss;
   assign bpq_bpredictor_meta        = r_out_meta;
   assign bpq_bpredictor_recover_ras = r_recover;
   assign bpq_fetch_redirect         = r_redirect;
   assign bpq_fetch_redirect_PC      = r_redirect_pc;

endmodule

// File: tb/tb_soin_bpredictor_update_queue.sv
// Directed self-checking bench for soin_bpredictor_update_queue.
module tb_soin_bpredictor_update_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_bpq_valid;
   logic [31:0] fetch_bpq_PC;
   logic        fetch_bpq_p_dir;
   logic [31:0] fetch_bpq_p_target;
   logic [19:0] fetch_bpq_meta;
   logic        bpq_fetch_full;
   logic        execute_bpq_resolve;
   logic        execute_bpq_is_cond;
   logic        execute_bpq_dir;
   logic [31:0] execute_bpq_target;
   logic        bpq_bpredictor_update;
   logic [31:0] bpq_bpredictor_PC;
   logic [31:0] bpq_bpredictor_target;
   logic        bpq_bpredictor_dir;
   logic        bpq_bpredictor_miss;
   logic [23:0] bpq_bpredictor_meta;
   logic        bpq_bpredictor_recover_ras;
   logic        bpq_fetch_redirect;
   logic [31:0] bpq_fetch_redirect_PC;
   logic [3:0]  bpq_count;
   logic        bpq_error;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   soin_bpredictor_update_queue dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .fetch_bpq_valid            (fetch_bpq_valid),
      .fetch_bpq_PC               (fetch_bpq_PC),
      .fetch_bpq_p_dir            (fetch_bpq_p_dir),
      .fetch_bpq_p_target         (fetch_bpq_p_target),
      .fetch_bpq_meta             (fetch_bpq_meta),
      .bpq_fetch_full             (bpq_fetch_full),
      .execute_bpq_resolve        (execute_bpq_resolve),
      .execute_bpq_is_cond        (execute_bpq_is_cond),
      .execute_bpq_dir            (execute_bpq_dir),
      .execute_bpq_target         (execute_bpq_target),
      .bpq_bpredictor_update      (bpq_bpredictor_update),
      .bpq_bpredictor_PC          (bpq_bpredictor_PC),
      .bpq_bpredictor_target      (bpq_bpredictor_target),
      .bpq_bpredictor_dir         (bpq_bpredictor_dir),
      .bpq_bpredictor_miss        (bpq_bpredictor_miss),
      .bpq_bpredictor_meta        (bpq_bpredictor_meta),
      .bpq_bpredictor_recover_ras (bpq_bpredictor_recover_ras),
      .bpq_fetch_redirect         (bpq_fetch_redirect),
      .bpq_fetch_redirect_PC      (bpq_fetch_redirect_PC),
      .bpq_count                  (bpq_count),
      .bpq_error                  (bpq_error)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic set_push(input logic [31:0] pc, input logic pdir, input logic [31:0] ptgt,
                           input logic [19:0] meta);
      fetch_bpq_valid    = 1'b1;
      fetch_bpq_PC       = pc;
      fetch_bpq_p_dir    = pdir;
      fetch_bpq_p_target = ptgt;
      fetch_bpq_meta     = meta;
   endtask

   task automatic set_res(input logic cond, input logic dir, input logic [31:0] tgt);
      execute_bpq_resolve = 1'b1;
      execute_bpq_is_cond = cond;
      execute_bpq_dir     = dir;
      execute_bpq_target  = tgt;
   endtask

   // Advance one edge, sample 1 time unit later, then drop the request strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      fetch_bpq_valid     = 1'b0;
      execute_bpq_resolve = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      fetch_bpq_valid = 1'b0; fetch_bpq_PC = '0; fetch_bpq_p_dir = 1'b0;
      fetch_bpq_p_target = '0; fetch_bpq_meta = '0;
      execute_bpq_resolve = 1'b0; execute_bpq_is_cond = 1'b0;
      execute_bpq_dir = 1'b0; execute_bpq_target = '0;
      tick(); tick();
      reset_n = 1'b1;
      chk("rst_count", 32'(bpq_count), 32'd0);
      chk("rst_full", 32'(bpq_fetch_full), 32'd0);
      chk("rst_error", 32'(bpq_error), 32'd0);
      chk("rst_update", 32'(bpq_bpredictor_update), 32'd0);
      chk("rst_redirect", 32'(bpq_fetch_redirect), 32'd0);
      chk("rst_meta", 32'(bpq_bpredictor_meta), 32'd0);
      chk("rst_pc", bpq_bpredictor_PC, 32'd0);

      // Correctly predicted taken conditional: counter k=0 goes 00 -> 01.
      set_push(32'h100, 1'b1, 32'h200, {4'h3, 8'b01_10_11_00, 8'h5A});
      tick();
      chk("t1_count", 32'(bpq_count), 32'd1);
      set_res(1'b1, 1'b1, 32'h200);
      tick();
      chk("t1_update", 32'(bpq_bpredictor_update), 32'd1);
      chk("t1_miss", 32'(bpq_bpredictor_miss), 32'd0);
      chk("t1_redirect", 32'(bpq_fetch_redirect), 32'd0);
      chk("t1_meta", 32'(bpq_bpredictor_meta), 32'h316D5A);
      chk("t1_pc", bpq_bpredictor_PC, 32'h100);
      chk("t1_count0", 32'(bpq_count), 32'd0);
      tick();
      chk("t1_pulse", 32'(bpq_bpredictor_update), 32'd0);
      chk("t1_hold_pc", bpq_bpredictor_PC, 32'h100);

      // Mispredict with three younger entries and a same-cycle push: all flushed.
      set_push(32'h10C, 1'b1, 32'h300, {4'h7, 8'b11_00_00_00, 8'h11}); tick();
      set_push(32'h200, 1'b0, 32'h204, 20'h0); tick();
      set_push(32'h204, 1'b0, 32'h208, 20'h0); tick();
      set_push(32'h208, 1'b0, 32'h20C, 20'h0); tick();
      chk("t2_count4", 32'(bpq_count), 32'd4);
      set_push(32'h400, 1'b0, 32'h404, 20'h0);
      set_res(1'b1, 1'b0, 32'h0);
      tick();
      chk("t2_miss", 32'(bpq_bpredictor_miss), 32'd1);
      chk("t2_ras", 32'(bpq_bpredictor_recover_ras), 32'd1);
      chk("t2_redirect", 32'(bpq_fetch_redirect), 32'd1);
      chk("t2_redir_pc", bpq_fetch_redirect_PC, 32'h110);
      chk("t2_update", 32'(bpq_bpredictor_update), 32'd1);
      chk("t2_meta", 32'(bpq_bpredictor_meta), 32'h718011);
      chk("t2_count0", 32'(bpq_count), 32'd0);

      // Saturation at 11 (taken) and at 00 (not taken); PC=0x130 selects byte 3.
      set_push(32'h130, 1'b1, 32'h500, {4'h0, 8'h03, 8'h00}); tick();
      set_res(1'b1, 1'b1, 32'h500); tick();
      chk("sat_hi_meta", 32'(bpq_bpredictor_meta), 32'h080300);
      chk("sat_hi_miss", 32'(bpq_bpredictor_miss), 32'd0);
      set_push(32'h104, 1'b0, 32'h108, {4'h0, 8'hF3, 8'h00}); tick();
      set_res(1'b1, 1'b0, 32'h108); tick();
      chk("sat_lo_meta", 32'(bpq_bpredictor_meta), 32'h01F300);
      chk("sat_lo_redirect", 32'(bpq_fetch_redirect), 32'd0);

      // Fill, overflow push, push+pop while full, then drain in order.
      for (int i = 0; i < 8; i++) begin
         set_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0, {12'h0, 8'(i)});
         tick();
      end
      chk("fill_count", 32'(bpq_count), 32'd8);
      chk("fill_full", 32'(bpq_fetch_full), 32'd1);
      set_push(32'hDEAD0000, 1'b0, 32'h0, 20'h0); tick();
      chk("ovf_count", 32'(bpq_count), 32'd8);
      set_push(32'hBEEF0000, 1'b0, 32'h0, 20'h0);
      set_res(1'b1, 1'b0, 32'h0);
      tick();
      chk("fullpp_pc", bpq_bpredictor_PC, 32'h1000);
      chk("fullpp_count", 32'(bpq_count), 32'd7);
      for (int i = 1; i < 8; i++) begin
         set_res(1'b1, 1'b0, 32'h0);
         tick();
         chk("drain_pc", bpq_bpredictor_PC, 32'h1000 + 32'(4 * i));
      end
      chk("drain_count", 32'(bpq_count), 32'd0);

      // Pointer wrap over 20 simultaneous push/pop cycles.
      set_push(32'h2000, 1'b0, 32'h0, 20'h0); tick();
      for (int i = 0; i < 20; i++) begin
         set_push(32'h2000 + 32'(4 * (i + 1)), 1'b0, 32'h0, 20'h0);
         set_res(1'b1, 1'b0, 32'h0);
         tick();
         chk("wrap_pc", bpq_bpredictor_PC, 32'h2000 + 32'(4 * i));
         chk("wrap_count", 32'(bpq_count), 32'd1);
      end
      set_res(1'b1, 1'b0, 32'h0); tick();
      chk("wrap_last_pc", bpq_bpredictor_PC, 32'h2050);
      chk("wrap_empty", 32'(bpq_count), 32'd0);

      // Unconditional branch with a wrong target.
      set_push(32'h3000, 1'b1, 32'h3100, 20'h0); tick();
      set_res(1'b0, 1'b1, 32'h3200); tick();
      chk("unc_update", 32'(bpq_bpredictor_update), 32'd0);
      chk("unc_miss", 32'(bpq_bpredictor_miss), 32'd1);
      chk("unc_redirect", 32'(bpq_fetch_redirect), 32'd1);
      chk("unc_redir_pc", bpq_fetch_redirect_PC, 32'h3200);
      chk("unc_target", bpq_bpredictor_target, 32'h3200);

      // Resolve while empty: no strobes, sticky error.
      set_res(1'b1, 1'b1, 32'h9999); tick();
      chk("emp_update", 32'(bpq_bpredictor_update), 32'd0);
      chk("emp_miss", 32'(bpq_bpredictor_miss), 32'd0);
      chk("emp_error", 32'(bpq_error), 32'd1);
      chk("emp_hold_pc", bpq_bpredictor_PC, 32'h3000);
      tick();
      chk("emp_sticky", 32'(bpq_error), 32'd1);

      // Reset mid-operation with five entries queued and pending requests.
      for (int i = 0; i < 5; i++) begin
         set_push(32'h4000 + 32'(4 * i), 1'b1, 32'h0, 20'h0);
         tick();
      end
      chk("pre_rst_count", 32'(bpq_count), 32'd5);
      reset_n = 1'b0;
      set_push(32'h5000, 1'b0, 32'h0, 20'h0);
      set_res(1'b1, 1'b0, 32'h0);
      tick();
      reset_n = 1'b1;
      chk("mrst_count", 32'(bpq_count), 32'd0);
      chk("mrst_error", 32'(bpq_error), 32'd0);
      chk("mrst_miss", 32'(bpq_bpredictor_miss), 32'd0);
      chk("mrst_update", 32'(bpq_bpredictor_update), 32'd0);
      chk("mrst_pc", bpq_bpredictor_PC, 32'd0);
      chk("mrst_full", 32'(bpq_fetch_full), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
